adpcm_main_mul_arbiter: RTL

//   Round-robin arbiter/sequencer that time-shares one adpcm_main_mul_16s_32s_46_2_1

---
 rtl/adpcm_main_mul_arbiter_pkg.sv | 17 +
 rtl/adpcm_main_mul_arbiter_if.sv | 32 +++
 rtl/adpcm_main_mul_16s_32s_46_2_1.sv | 32 +++
 rtl/adpcm_main_rr_arb.sv | 42 ++++
 rtl/adpcm_main_mul_arbiter.sv | 87 ++++++++
 5 files changed

// File: rtl/adpcm_main_mul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adpcm_main_pkg
// Brief   : Shared widths and operand types for the ADPCM shared multiplier.
// Revision: 1.0
// ============================================================================
package adpcm_main_pkg;
  localparam int MUL_A_W = 16;
  localparam int MUL_B_W = 32;
  localparam int MUL_P_W = 46;
  localparam int MUL_LAT = 1;

  typedef logic [MUL_A_W-1:0] mul_a_t;
  typedef logic [MUL_B_W-1:0] mul_b_t;
  typedef logic [MUL_P_W-1:0] mul_p_t;
endpackage
`default_nettype wire

// File: rtl/adpcm_main_mul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : adpcm_main_mul_arbiter_if
// Brief   : Request/response bundle between requesters and the shared multiplier.
// Revision: 1.0
// ============================================================================
interface adpcm_main_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import adpcm_main_pkg::*;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*MUL_A_W-1:0] req_a;
  logic [NREQ*MUL_B_W-1:0] req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  mul_p_t                  rsp_data;
  logic [IDW-1:0]          rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface
`default_nettype wire

// File: rtl/adpcm_main_mul_16s_32s_46_2_1.sv
`default_nettype none
// ============================================================================
// Module  : adpcm_main_mul_16s_32s_46_2_1
// Brief   : Signed 16x32 multiplier, low 46 product bits, one ce-gated register.
// Revision: 1.0
// ============================================================================
module adpcm_main_mul_16s_32s_46_2_1
  import adpcm_main_pkg::*;
(
  input  wire logic clk,
  input  wire logic ce,
  input  wire mul_a_t din0,
  input  wire mul_b_t din1,
  output mul_p_t    dout
);
  logic signed [MUL_P_W-1:0] w_a;
  logic signed [MUL_P_W-1:0] w_b;
  mul_p_t                    r_p;

  // Sign-extend to the product width so the multiply wraps modulo 2^46.
  assign w_a = MUL_P_W'($signed(din0));
  assign w_b = MUL_P_W'($signed(din1));

  always_ff @(posedge clk) begin
    if (ce) begin
      r_p <= w_a * w_b;
    end
  end

  assign dout = r_p;
endmodule
`default_nettype wire

// File: rtl/adpcm_main_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : adpcm_main_rr_arb
// Brief   : Round-robin pick starting at ptr; one-hot grant gated by en.
// Revision: 1.0
// ============================================================================
module adpcm_main_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  wire logic [NREQ-1:0] i_req,
  input  wire logic [IDW-1:0]  i_ptr,
  input  wire logic            i_en,
  output logic      [NREQ-1:0] o_grant,
  output logic      [IDW-1:0]  o_win,
  output logic      [IDW-1:0]  o_nxt_ptr,
  output logic                 o_any
);
  logic        w_found;
  int unsigned w_idx;

  always_comb begin
    w_found   = 1'b0;
    w_idx     = 0;
    o_win     = '0;
    o_grant   = '0;
    // Scan farthest offset first so the nearest requester past ptr wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % NREQ;
      if (i_req[w_idx]) begin
        w_found = 1'b1;
        o_win   = IDW'(w_idx);
      end
    end
    o_nxt_ptr = (o_win == IDW'(NREQ - 1)) ? '0 : o_win + 1'b1;
    o_any     = w_found && i_en;
    if (o_any) begin
      o_grant[o_win] = 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/adpcm_main_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : adpcm_main_mul_arbiter
// Brief   : Time-shares one multiplier among NREQ requesters with tagged responses.
// Revision: 1.0
// ============================================================================
module adpcm_main_mul_arbiter
  import adpcm_main_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  wire logic               clk,
  input  wire logic               reset,
  adpcm_main_mul_arbiter_if.slave bus,
  output logic                    busy
);
  logic           r_s1_vld;
  logic           r_s2_vld;
  logic [IDW-1:0] r_s1_id;
  logic [IDW-1:0] r_s2_id;
  logic [IDW-1:0] r_rr_ptr;
  mul_a_t         r_op_a;
  mul_b_t         r_op_b;

  logic            w_adv;
  logic            w_en;
  logic            w_take;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_nxt_ptr;
  mul_p_t          w_prod;

  assign w_adv = !r_s2_vld || bus.rsp_ready;
  // Reset also gates the grant so req_ready drops asynchronously with it.
  assign w_en  = w_adv && reset;

  adpcm_main_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req     (bus.req_valid),
    .i_ptr     (r_rr_ptr),
    .i_en      (w_en),
    .o_grant   (w_grant),
    .o_win     (w_win),
    .o_nxt_ptr (w_nxt_ptr),
    .o_any     (w_take)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s1_id  <= '0;
      r_s2_id  <= '0;
      r_rr_ptr <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
    end else if (w_adv) begin
      r_s1_vld <= w_take;
      r_s2_vld <= r_s1_vld;
      r_s2_id  <= r_s1_id;
      if (w_take) begin
        r_op_a   <= bus.req_a[w_win*MUL_A_W +: MUL_A_W];
        r_op_b   <= bus.req_b[w_win*MUL_B_W +: MUL_B_W];
        r_s1_id  <= w_win;
        r_rr_ptr <= w_nxt_ptr;
      end
    end
  end

  adpcm_main_mul_16s_32s_46_2_1 u_mul (
    .clk  (clk),
    .ce   (w_adv),
    .din0 (r_op_a),
    .din1 (r_op_b),
    .dout (w_prod)
  );

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_s2_vld;
  assign bus.rsp_data  = w_prod;
  assign bus.rsp_id    = r_s2_id;
  assign busy          = r_s1_vld || r_s2_vld;
endmodule
`default_nettype wire
